fma_arbiter: RTL and testbench

Round-robin arbiter that shares one `fp_fma` multiply-add pipeline among `requesters` independent clients. Each granted request is tagged with the client index and a per-client sequence number in the FMA `iid` field. Each result is steered back to the originating client using `oid`. Per-client credit counters bound in-flight operations, so one stalled client cannot fill the shared pipeline.

---
 rtl/fma_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_fma_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fma_arbiter.sv
// fma_arbiter: round-robin front end sharing one fp_fma pipeline among
// `requesters` clients. Requests are tagged {seq, client} in the FMA id,
// results are steered back by that id, and per-client credits bound how
// much of the pipeline one client can occupy.
// Optional build macro FMA_ARB_STATS_EN adds grant and issue-stall counters.

module fma_arbiter #(
  parameter int requesters      = 4,
  parameter int ibits           = 12,
  parameter int fbits           = 20,
  parameter int id_bits         = 8,
  parameter int max_outstanding = 4
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [requesters-1:0]                    req_valid,
  output logic [requesters-1:0]                    req_ready,
  input  logic [requesters*(ibits+fbits)-1:0]      req_a,
  input  logic [requesters*(ibits+fbits)-1:0]      req_b,
  input  logic [requesters*2*(ibits+fbits)-1:0]    req_c,
  output logic [requesters-1:0]                    rsp_valid,
  input  logic [requesters-1:0]                    rsp_ack,
  output logic [2*(ibits+fbits):0]                 rsp_r,
  output logic [id_bits-$clog2(requesters)-1:0]    rsp_seq,
  output logic [ibits+fbits-1:0]                   fma_a,
  output logic [ibits+fbits-1:0]                   fma_b,
  output logic [2*(ibits+fbits)-1:0]               fma_c,
  output logic [id_bits-1:0]                       fma_iid,
  output logic                                     fma_ivalid,
  input  logic                                     fma_iready,
  input  logic [2*(ibits+fbits):0]                 fma_r,
  input  logic [id_bits-1:0]                       fma_oid,
  input  logic                                     fma_ovalid,
  output logic                                     fma_oack,
  output logic                                     orphan
`ifdef FMA_ARB_STATS_EN
  ,
  output logic [requesters*16-1:0]                 stat_grants,
  output logic [15:0]                              stat_stall
`endif
);

  localparam int W  = ibits + fbits;
  localparam int ix = $clog2(requesters);
  localparam int sw = id_bits - ix;
  localparam int cw = $clog2(max_outstanding + 1);

  // issue entry
  logic                 ent_valid;
  logic [W-1:0]         ent_a;
  logic [W-1:0]         ent_b;
  logic [2*W-1:0]       ent_c;
  logic [id_bits-1:0]   ent_iid;

  // per-client bookkeeping
  logic [requesters-1:0][cw-1:0] outstanding;
  logic [requesters-1:0][sw-1:0] seq;
  logic [ix-1:0]                 rr_ptr;

  // combinational arbitration / steering
  logic                  entry_free;
  logic [requesters-1:0] eligible;
  logic [requesters-1:0] grant;
  logic [requesters-1:0] done;
  logic [ix-1:0]         gidx;
  logic [ix-1:0]         rr_next;
  logic                  found;
  int                    cand;
  logic                  accept;
  logic [W-1:0]          sel_a;
  logic [W-1:0]          sel_b;
  logic [2*W-1:0]        sel_c;
  logic                  rsp_hit;
  logic                  drop;

  assign fma_a      = ent_a;
  assign fma_b      = ent_b;
  assign fma_c      = ent_c;
  assign fma_iid    = ent_iid;
  assign fma_ivalid = ent_valid;

  assign rsp_r   = fma_r;
  assign rsp_seq = fma_oid[id_bits-1:ix];

  // A client may issue only while it has credit and the entry can take a new op;
  // nothing is accepted while reset is held.
  always_comb begin
    entry_free = !ent_valid || fma_iready;
    eligible   = '0;
    for (int i = 0; i < requesters; i++) begin
      eligible[i] = reset && req_valid[i] &&
                    (outstanding[i] < cw'(max_outstanding)) && entry_free;
    end
  end

  // Round-robin search: first eligible client at or after rr_ptr, wrapping.
  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    cand  = 0;
    for (int o = 0; o < requesters; o++) begin
      cand = int'(rr_ptr) + o;
      if (cand >= requesters) cand = cand - requesters;
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        gidx        = ix'(cand);
      end
    end
    accept    = found;
    req_ready = grant;
    rr_next   = (gidx == ix'(requesters - 1)) ? '0 : gidx + ix'(1);
  end

  // Select the granted client's operands for the issue entry.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_c = '0;
    for (int i = 0; i < requesters; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
        sel_c = req_c[i*2*W +: 2*W];
      end
    end
  end

  // Steer the FMA result by its id; results for clients without credit
  // (or with an out-of-range index) are orphans and are drained unconditionally.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < requesters; i++) begin
      if (fma_ovalid && (fma_oid[ix-1:0] == ix'(i)) && (outstanding[i] != '0)) begin
        rsp_valid[i] = 1'b1;
      end
    end
    rsp_hit  = |rsp_valid;
    done     = rsp_valid & rsp_ack;
    fma_oack = rsp_hit ? |done : 1'b1;
    drop     = fma_ovalid && !rsp_hit;
  end

  // Issue entry: load on accept, empty when the FMA takes it, otherwise hold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ent_valid <= 1'b0;
      ent_a     <= '0;
      ent_b     <= '0;
      ent_c     <= '0;
      ent_iid   <= '0;
    end else if (accept) begin
      ent_valid <= 1'b1;
      ent_a     <= sel_a;
      ent_b     <= sel_b;
      ent_c     <= sel_c;
      ent_iid   <= {seq[gidx], gidx};
    end else if (fma_iready) begin
      ent_valid <= 1'b0;
    end
  end

  // Credits: +1 on accept, -1 on response handshake, unchanged when both.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
    end else begin
      for (int i = 0; i < requesters; i++) begin
        if (grant[i] && !done[i]) begin
          outstanding[i] <= outstanding[i] + cw'(1);
        end else if (!grant[i] && done[i]) begin
          outstanding[i] <= outstanding[i] - cw'(1);
        end
      end
    end
  end

  // Per-client sequence numbers and the round-robin pointer advance on accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seq    <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      seq[gidx] <= seq[gidx] + sw'(1);
      rr_ptr    <= rr_next;
    end
  end

  // Sticky flag for results that arrived with no client waiting for them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      orphan <= 1'b0;
    end else if (drop) begin
      orphan <= 1'b1;
    end
  end

`ifdef FMA_ARB_STATS_EN
  // Saturating per-client grant counters and issue-stall cycle counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_grants <= '0;
      stat_stall  <= '0;
    end else begin
      for (int i = 0; i < requesters; i++) begin
        if (grant[i] && (stat_grants[i*16 +: 16] != 16'hFFFF)) begin
          stat_grants[i*16 +: 16] <= stat_grants[i*16 +: 16] + 16'd1;
        end
      end
      if (ent_valid && !fma_iready && (stat_stall != 16'hFFFF)) begin
        stat_stall <= stat_stall + 16'd1;
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_fma_arbiter.sv
// Directed bench for fma_arbiter (4 clients, Q12.20 operands, 7-bit id).
// A small in-order FMA model with one cycle of latency sits on the fma_* side.

module tb_fma_arbiter;

  localparam int N   = 4;
  localparam int IB  = 12;
  localparam int FB  = 20;
  localparam int W   = IB + FB;
  localparam int IDB = 7;
  localparam int SW  = 5;
  localparam int MO  = 4;
  localparam int LAT = 1;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [N-1:0]       req_valid = '0;
  logic [N-1:0]       req_ready;
  logic [N*W-1:0]     req_a = '0;
  logic [N*W-1:0]     req_b = '0;
  logic [N*2*W-1:0]   req_c = '0;
  logic [N-1:0]       rsp_valid;
  logic [N-1:0]       rsp_ack = '1;
  logic [2*W:0]       rsp_r;
  logic [SW-1:0]      rsp_seq;
  logic [W-1:0]       fma_a;
  logic [W-1:0]       fma_b;
  logic [2*W-1:0]     fma_c;
  logic [IDB-1:0]     fma_iid;
  logic               fma_ivalid;
  logic               fma_iready = 1'b1;
  logic [2*W:0]       fma_r = '0;
  logic [IDB-1:0]     fma_oid = '0;
  logic               fma_ovalid = 1'b0;
  logic               fma_oack;
  logic               orphan;
`ifdef FMA_ARB_STATS_EN
  logic [N*16-1:0]    stat_grants;
  logic [15:0]        stat_stall;
`endif

  int checks = 0;
  int errors = 0;

  fma_arbiter #(
    .requesters(N), .ibits(IB), .fbits(FB), .id_bits(IDB), .max_outstanding(MO)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_r(rsp_r), .rsp_seq(rsp_seq),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_iid(fma_iid),
    .fma_ivalid(fma_ivalid), .fma_iready(fma_iready),
    .fma_r(fma_r), .fma_oid(fma_oid), .fma_ovalid(fma_ovalid), .fma_oack(fma_oack),
    .orphan(orphan)
`ifdef FMA_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_stall(stat_stall)
`endif
  );

  always #5 clock = ~clock;

  // ---------------- FMA model: in-order queue, r = a*b + c ----------------
  typedef struct {
    logic [2*W:0]   r;
    logic [IDB-1:0] id;
    int             t;
  } fq_t;
  fq_t fq[$];
  int  cyc = 0;

  function automatic logic [2*W:0] fma_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2*W-1:0] c);
    longint sa;
    longint sb;
    logic [2*W-1:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = 64'(sa * sb);
    return {p[2*W-1], p} + {c[2*W-1], c};
  endfunction

  always @(posedge clock) begin
    fq_t e;
    cyc++;
    if (fma_ovalid && fma_oack && fq.size() > 0) fq.delete(0);
    if (fma_ivalid && fma_iready) begin
      e.r  = fma_calc(fma_a, fma_b, fma_c);
      e.id = fma_iid;
      e.t  = cyc;
      fq.push_back(e);
    end
    if (fq.size() > 0 && (cyc - fq[0].t) >= LAT) begin
      fma_ovalid <= 1'b1;
      fma_r      <= fq[0].r;
      fma_oid    <= fq[0].id;
    end else begin
      fma_ovalid <= 1'b0;
    end
  end

  // ---------------- helpers ----------------
  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] c);
    req_a[i*W +: W]     = a;
    req_b[i*W +: W]     = b;
    req_c[i*2*W +: 2*W] = c;
  endtask

  task automatic do_reset;
    req_valid  = '0;
    rsp_ack    = '1;
    fma_iready = 1'b1;
    reset      = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic drain;
    int n;
    n = 0;
    req_valid  = '0;
    rsp_ack    = '1;
    fma_iready = 1'b1;
    while ((fq.size() > 0 || fma_ovalid) && n < 100) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (fq.size() > 0 || fma_ovalid) begin
      errors++;
      $display("FAIL drain: %0d results still queued, required 0", fq.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset     = 1'b0;
    req_valid = 4'hF;
    #2;
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    checks++; if (rsp_valid !== 4'h0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    checks++; if (fma_ivalid !== 1'b0) begin errors++; $display("FAIL reset_fma_ivalid: got %b want 0", fma_ivalid); end
    checks++; if (fma_iid !== 7'h00 || fma_a !== '0) begin errors++; $display("FAIL reset_payload: iid %h a %h want 0", fma_iid, fma_a); end
    checks++; if (fma_oack !== 1'b1) begin errors++; $display("FAIL reset_fma_oack: got %b want 1", fma_oack); end
    checks++; if (orphan !== 1'b0) begin errors++; $display("FAIL reset_orphan: got %b want 0", orphan); end
    req_valid = '0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_idle_ready: got %b want 0000", req_ready); end
  endtask

  task automatic test_round_robin;
    logic [N-1:0] exp;
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, W'(32'h0010_0000 * (i + 1)), 32'h0010_0000, '0);
    req_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      exp = 4'b0001 << (i % 4);
      #1;
      checks++; if (req_ready !== exp) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", i, req_ready, exp); end
      @(negedge clock); #1;
      checks++; if (fma_ivalid !== 1'b1 || fma_iid !== 7'(i)) begin
        errors++; $display("FAIL rr_iid%0d: ivalid %b iid %h want 1 / %h", i, fma_ivalid, fma_iid, 7'(i));
      end
    end
    req_valid = '0;
    drain();
  endtask

  task automatic test_credit_limit;
    do_reset();
    set_op(0, 32'h0001_0000, 32'h0002_0000, '0);
    set_op(2, 32'h0003_0000, 32'h0004_0000, '0);
    rsp_ack   = 4'b1011;
    req_valid = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL credit_issue%0d: got %b want 0100", i, req_ready); end
      @(negedge clock);
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL credit_block%0d: got %b want 0000", i, req_ready); end
      @(negedge clock);
    end
    checks++; if (fma_oack !== 1'b0) begin errors++; $display("FAIL credit_oack_stall: got %b want 0", fma_oack); end
    req_valid = 4'b0101;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL credit_other_client: got %b want 0001", req_ready); end
    @(negedge clock);
    req_valid = 4'b0100;
    #1;
    checks++; if (rsp_valid !== 4'b0100 || rsp_seq !== 5'd0) begin
      errors++; $display("FAIL credit_head: rsp_valid %b seq %0d want 0100 / 0", rsp_valid, rsp_seq);
    end
    rsp_ack = 4'b1111;
    @(negedge clock);
    rsp_ack = 4'b1011;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL credit_return: got %b want 0100", req_ready); end
    checks++; if (rsp_valid !== 4'b0100 || rsp_seq !== 5'd1) begin
      errors++; $display("FAIL credit_next: rsp_valid %b seq %0d want 0100 / 1", rsp_valid, rsp_seq);
    end
    @(negedge clock); #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL credit_reblock: got %b want 0000", req_ready); end
    drain();
  endtask

  task automatic test_steering;
    int n;
    do_reset();
    set_op(1, 32'h0030_0000, 32'hFFE0_0000, '0);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL steer_grant: got %b want 0010", req_ready); end
    @(negedge clock);
    req_valid = '0;
    n = 0;
    while (!fma_ovalid && n < 20) begin @(negedge clock); n++; end
    #1;
    checks++; if (!fma_ovalid) begin errors++; $display("FAIL steer_timeout: no result after %0d cycles, want 1", n); end
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL steer_valid: got %b want 0010", rsp_valid); end
    checks++; if (rsp_r !== 65'h1_FFFF_FA00_0000_0000) begin errors++; $display("FAIL steer_r: got %h want 1fffffa0000000000", rsp_r); end
    checks++; if (rsp_seq !== 5'd0 || fma_oack !== 1'b1) begin errors++; $display("FAIL steer_seq_oack: seq %0d oack %b want 0 / 1", rsp_seq, fma_oack); end
    drain();
    checks++; if (orphan !== 1'b0) begin errors++; $display("FAIL steer_orphan: got %b want 0", orphan); end
  endtask

  task automatic test_issue_stall;
    do_reset();
    set_op(0, 32'h0001_2345, 32'h0006_789A, 64'h0000_0000_0BCD_EF01);
    set_op(1, 32'h0002_0000, 32'h0003_0000, '0);
    fma_iready = 1'b0;
    req_valid  = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL stall_first: got %b want 0001", req_ready); end
    @(negedge clock);
    req_valid = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); @(negedge clock); #1;
      checks++;
      if (fma_ivalid !== 1'b1 || fma_a !== 32'h0001_2345 || fma_b !== 32'h0006_789A ||
          fma_c !== 64'h0000_0000_0BCD_EF01 || fma_iid !== 7'h00 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL stall_hold%0d: ivalid %b a %h iid %h ready %b want 1 / 00012345 / 00 / 0000",
                 i, fma_ivalid, fma_a, fma_iid, req_ready);
      end
    end
`ifdef FMA_ARB_STATS_EN
    checks++; if (stat_stall !== 16'd5) begin errors++; $display("FAIL stall_stat: got %0d want 5", stat_stall); end
`endif
    fma_iready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL stall_release: got %b want 0010", req_ready); end
    @(negedge clock);
    req_valid = '0;
    #1;
    checks++; if (fma_iid !== 7'h01 || fma_a !== 32'h0002_0000) begin
      errors++; $display("FAIL stall_next_issue: iid %h a %h want 01 / 00020000", fma_iid, fma_a);
    end
    drain();
  endtask

  task automatic test_reset_mid;
    int  n;
    logic bad;
    do_reset();
    for (int i = 0; i < 3; i++) set_op(i, W'(32'h0001_0000 * (i + 1)), 32'h0001_0000, '0);
    rsp_ack = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      req_valid = 4'b0001 << i;
      @(negedge clock);
    end
    req_valid = '0;
    @(negedge clock);
    req_valid = 4'hF;
    #1;
    checks++; if (req_ready !== 4'b1000 || rsp_valid !== 4'b0001 || fma_oack !== 1'b0) begin
      errors++; $display("FAIL mid_before: ready %b rsp_valid %b oack %b want 1000 / 0001 / 0", req_ready, rsp_valid, fma_oack);
    end
    #1 reset = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000 || fma_oack !== 1'b1 || fma_ivalid !== 1'b0) begin
      errors++; $display("FAIL mid_async: ready %b rsp_valid %b oack %b ivalid %b want 0000 / 0000 / 1 / 0",
                         req_ready, rsp_valid, fma_oack, fma_ivalid);
    end
    req_valid = '0;
    #1 reset = 1'b1;
    n   = 0;
    bad = 1'b0;
    while ((fq.size() > 0 || fma_ovalid) && n < 30) begin
      @(negedge clock); #1;
      if (rsp_valid !== 4'b0000) bad = 1'b1;
      if (fma_ovalid && fma_oack !== 1'b1) bad = 1'b1;
      n++;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL mid_drain_clean: got %b want 0", bad); end
    checks++; if (fq.size() != 0) begin errors++; $display("FAIL mid_drained: %0d left want 0", fq.size()); end
    checks++; if (orphan !== 1'b1) begin errors++; $display("FAIL mid_orphan: got %b want 1", orphan); end
    rsp_ack = '1;
  endtask

  task automatic test_back_to_back;
    int cnt;
    int acc_n;
    int n;
    logic acc;
    logic done;
    logic pend;
    logic seen;
    logic [SW-1:0]  iss_seq;
    logic [SW-1:0]  rsp_exp;
    logic [IDB-1:0] exp_iid;
    do_reset();
    set_op(0, 32'h0000_8000, 32'h0000_4000, 64'd7);
    cnt = 0; acc_n = 0; n = 0; pend = 1'b0; seen = 1'b0;
    iss_seq = '0; rsp_exp = '0; exp_iid = '0;
    req_valid = 4'b0001;
    while (acc_n < 34 && n < 300) begin
      #1;
      if (pend) begin
        checks++; if (fma_iid !== exp_iid) begin errors++; $display("FAIL b2b_iid%0d: got %h want %h", acc_n, fma_iid, exp_iid); end
        pend = 1'b0;
      end
      checks++; if (req_ready[0] !== (cnt < MO)) begin errors++; $display("FAIL b2b_ready: got %b credits %0d", req_ready[0], cnt); end
      checks++; if (rsp_valid[0] !== (fma_ovalid && cnt != 0)) begin errors++; $display("FAIL b2b_rsp_valid: got %b credits %0d", rsp_valid[0], cnt); end
      acc  = req_ready[0];
      done = rsp_valid[0] && rsp_ack[0];
      if (done) begin
        checks++; if (rsp_seq !== rsp_exp) begin errors++; $display("FAIL b2b_rsp_seq: got %0d want %0d", rsp_seq, rsp_exp); end
        rsp_exp++;
      end
      if (acc) begin
        exp_iid = {iss_seq, 2'b00};
        iss_seq++;
        pend = 1'b1;
        acc_n++;
      end
      if (acc && done) seen = 1'b1;
      cnt = cnt + int'(acc) - int'(done);
      @(negedge clock);
      n++;
    end
    #1;
    if (pend) begin
      checks++; if (fma_iid !== exp_iid) begin errors++; $display("FAIL b2b_iid_last: got %h want %h", fma_iid, exp_iid); end
    end
    checks++; if (acc_n < 34) begin errors++; $display("FAIL b2b_accepts: got %0d want 34", acc_n); end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL b2b_simultaneous: got %b want 1", seen); end
    req_valid = '0;
    drain();
  endtask

  initial begin
    #1;
    test_reset();
    test_round_robin();
    test_credit_limit();
    test_steering();
    test_issue_stall();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1);
  end

endmodule
